// File: rtl/config_bank_loader_pkg.sv
// Shared types and width helpers for the configuration bank loader.
package config_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SETUP = 3'd2,
        PULSE = 3'd3,
        HOLD  = 3'd4,
        DONE  = 3'd5
    } state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Width of an index able to hold 0..n-1, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/config_bank_loader_if.sv
// Config word stream. A word moves on any rising edge where s_valid and
// s_ready are both 1; the source holds s_data/s_valid until that edge.
interface config_bank_loader_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/config_bank_loader_bl_row_assembler.sv
// Collects WPR stream words into one bit-line row; shadow shows the row
// including any word accepted this cycle so the top can latch it at once.
module bl_row_assembler
    import config_loader_pkg::*;
#(
    parameter int BL_W   = 514,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] word,
    input  logic              accept,
    input  logic              clear,
    output logic [BL_W-1:0]   shadow,
    output logic              last_word
);
    localparam int WPR   = ceil_div(BL_W, DATA_W);
    localparam int IDX_W = width_of(WPR);

    logic [IDX_W-1:0] idx;
    logic [BL_W-1:0]  shadow_q;

    assign last_word = accept && (idx == IDX_W'(WPR - 1));

    // Bits of the final word that land at or beyond BL_W have no slot here.
    for (genvar j = 0; j < BL_W; j++) begin : g_bit
        localparam logic [IDX_W-1:0] K = IDX_W'(j / DATA_W);
        localparam int I = j % DATA_W;
        assign shadow[j] = (accept && idx == K) ? word[I] : shadow_q[j];
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            idx      <= '0;
            shadow_q <= '0;
        end else if (accept) begin
            shadow_q <= shadow;
            idx      <= last_word ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/config_bank_loader.sv
// Streams config words into rows, then strobes each word line with
// setup/pulse/hold timing and releases the fabric reset when all rows land.
module config_bank_loader
    import config_loader_pkg::*;
#(
    parameter int  BL_W      = 514,
    parameter int  WL_ROWS   = 407,
    parameter int  DATA_W    = 32,
    parameter int  SETUP_CYC = 2,
    parameter int  PULSE_CYC = 4,
    parameter int  HOLD_CYC  = 2,
    localparam int ROW_AW    = width_of(WL_ROWS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    config_bank_loader_if.slave    s,
    output logic [BL_W-1:0]        bl,
    output logic [WL_ROWS-1:0]     wl,
    output logic                   busy,
    output logic                   done,
    output logic                   fabric_resetn,
    output logic [ROW_AW-1:0]      cur_row,
    output state_t                 state
);
    localparam int TMR_W = width_of(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC));

    logic [TMR_W-1:0] timer;
    logic [BL_W-1:0]  shadow;
    logic             last_word;
    logic             accept;
    logic             clear;

    assign accept = s.s_valid && s.s_ready;
    assign clear  = start && (state == IDLE || state == DONE);

    bl_row_assembler #(
        .BL_W   (BL_W),
        .DATA_W (DATA_W)
    ) u_asm (
        .clk       (clk),
        .reset     (reset),
        .word      (s.s_data),
        .accept    (accept),
        .clear     (clear),
        .shadow    (shadow),
        .last_word (last_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            s.s_ready     <= 1'b0;
            bl            <= '0;
            wl            <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            fabric_resetn <= 1'b0;
            cur_row       <= '0;
            timer         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        busy      <= 1'b1;
                        s.s_ready <= 1'b1;
                        cur_row   <= '0;
                    end
                end
                LOAD: begin
                    if (last_word) begin
                        bl        <= shadow;
                        s.s_ready <= 1'b0;
                        timer     <= TMR_W'(SETUP_CYC - 1);
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (timer == '0) begin
                        wl    <= WL_ROWS'(1) << cur_row;
                        timer <= TMR_W'(PULSE_CYC - 1);
                        state <= PULSE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                PULSE: begin
                    if (timer == '0) begin
                        wl    <= '0;
                        timer <= TMR_W'(HOLD_CYC - 1);
                        state <= HOLD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                HOLD: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (cur_row < ROW_AW'(WL_ROWS - 1)) begin
                        cur_row   <= cur_row + 1'b1;
                        s.s_ready <= 1'b1;
                        state     <= LOAD;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Fabric reset lifts one cycle after done rises.
                    if (start) begin
                        done          <= 1'b0;
                        fabric_resetn <= 1'b0;
                        busy          <= 1'b1;
                        s.s_ready     <= 1'b1;
                        cur_row       <= '0;
                        state         <= LOAD;
                    end else begin
                        fabric_resetn <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_config_bank_loader.sv
// Directed bench for config_bank_loader at BL_W=10, WL_ROWS=3, DATA_W=4.
module tb_config_bank_loader;
  import config_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  bl;
  logic [2:0]  wl;
  logic        busy;
  logic        done;
  logic        fabric_resetn;
  logic [1:0]  cur_row;
  state_t      dbg_state;
  int          checks = 0;
  int          failures = 0;

  config_bank_loader_if #(.DATA_W(4)) s_if ();

  config_bank_loader #(
    .BL_W(10), .WL_ROWS(3), .DATA_W(4),
    .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .s(s_if.slave),
    .bl(bl), .wl(wl), .busy(busy), .done(done),
    .fabric_resetn(fabric_resetn), .cur_row(cur_row), .state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] d);
    int n = 0;
    @(negedge clk);
    s_if.s_valid = 1'b1;
    s_if.s_data  = d;
    while (!s_if.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_word_wait", 32'(n < 50), 32'd1);
    step();
  endtask

  // Entered just after the edge that accepted the row's last word.
  task automatic row_check(input logic [9:0] exp_bl, input logic [2:0] exp_wl,
                           input logic [1:0] row, input bit last, input bit poke_start);
    chk("setup_state", 32'(dbg_state), 32'(SETUP));
    chk("setup_bl", 32'(bl), 32'(exp_bl));
    chk("setup_wl", 32'(wl), 32'd0);
    chk("setup_ready", 32'(s_if.s_ready), 32'd0);
    if (poke_start) begin
      @(negedge clk); start = 1'b1;
    end
    step();
    start = 1'b0;
    chk("pulse1_state", 32'(dbg_state), 32'(PULSE));
    chk("pulse1_wl", 32'(wl), 32'(exp_wl));
    chk("pulse1_bl", 32'(bl), 32'(exp_bl));
    chk("pulse1_row", 32'(cur_row), 32'(row));
    chk("pulse1_busy", 32'(busy), 32'd1);
    step();
    chk("pulse2_wl", 32'(wl), 32'(exp_wl));
    chk("pulse2_bl", 32'(bl), 32'(exp_bl));
    step();
    chk("hold_state", 32'(dbg_state), 32'(HOLD));
    chk("hold_wl", 32'(wl), 32'd0);
    chk("hold_bl", 32'(bl), 32'(exp_bl));
    step();
    if (!last) begin
      chk("next_state", 32'(dbg_state), 32'(LOAD));
      chk("next_row", 32'(cur_row), 32'(row + 2'd1));
      chk("next_ready", 32'(s_if.s_ready), 32'd1);
      chk("next_wl", 32'(wl), 32'd0);
    end else begin
      chk("done_state", 32'(dbg_state), 32'(DONE));
      chk("done_flag", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_resetn_early", 32'(fabric_resetn), 32'd0);
      step();
      chk("done_resetn", 32'(fabric_resetn), 32'd1);
      chk("done_flag_hold", 32'(done), 32'd1);
    end
  endtask

  task automatic nominal_load();
    send_word(4'h1); send_word(4'h2); send_word(4'h3);
    row_check(10'h321, 3'b001, 2'd0, 1'b0, 1'b0);
    send_word(4'hF); send_word(4'hF); send_word(4'hF);
    row_check(10'h3FF, 3'b010, 2'd1, 1'b0, 1'b0);
    send_word(4'h0); send_word(4'h0); send_word(4'h0);
    row_check(10'h000, 3'b100, 2'd2, 1'b1, 1'b0);
  endtask

  initial begin
    logic       bp_valid [6];
    logic [3:0] bp_data  [6];
    bp_valid = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bp_data  = '{4'h5, 4'hE, 4'hE, 4'h6, 4'hE, 4'h7};
    s_if.s_valid = 1'b0;
    s_if.s_data  = 4'h0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_ready", 32'(s_if.s_ready), 32'd0);
    chk("rst_bl", 32'(bl), 32'd0);
    chk("rst_wl", 32'(wl), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_resetn", 32'(fabric_resetn), 32'd0);
    chk("rst_row", 32'(cur_row), 32'd0);

    // Idle stream: valid words offered in IDLE must not be taken
    @(negedge clk); s_if.s_valid = 1'b1; s_if.s_data = 4'hA;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("idle_ready", 32'(s_if.s_ready), 32'd0);
      chk("idle_bl", 32'(bl), 32'd0);
      chk("idle_state", 32'(dbg_state), 32'(IDLE));
    end
    @(negedge clk); s_if.s_valid = 1'b0;

    // Nominal full load
    pulse_start();
    chk("start_state", 32'(dbg_state), 32'(LOAD));
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_ready", 32'(s_if.s_ready), 32'd1);
    nominal_load();

    // Reload from DONE
    @(negedge clk); s_if.s_valid = 1'b0;
    pulse_start();
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_resetn", 32'(fabric_resetn), 32'd0);
    chk("reload_busy", 32'(busy), 32'd1);
    chk("reload_ready", 32'(s_if.s_ready), 32'd1);
    chk("reload_row", 32'(cur_row), 32'd0);

    // Backpressure gaps on row 0
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      s_if.s_valid = bp_valid[c];
      s_if.s_data  = bp_data[c];
      step();
      chk("bp_row", 32'(cur_row), 32'd0);
      chk("bp_wl", 32'(wl), 32'd0);
      if (c < 5) begin
        chk("bp_bl_hold", 32'(bl), 32'd0);
        chk("bp_state", 32'(dbg_state), 32'(LOAD));
      end
    end
    row_check(10'h365, 3'b001, 2'd0, 1'b0, 1'b0);

    // start during row 1 SETUP is ignored
    send_word(4'hA); send_word(4'h5); send_word(4'h2);
    row_check(10'h25A, 3'b010, 2'd1, 1'b0, 1'b1);
    send_word(4'h1); send_word(4'h8); send_word(4'h1);
    row_check(10'h181, 3'b100, 2'd2, 1'b1, 1'b0);

    // Reset in the second PULSE cycle of row 1
    pulse_start();
    send_word(4'h1); send_word(4'h2); send_word(4'h3);
    row_check(10'h321, 3'b001, 2'd0, 1'b0, 1'b0);
    send_word(4'hF); send_word(4'hF); send_word(4'hF);
    step();
    chk("mid_pulse1_wl", 32'(wl), 32'b010);
    step();
    chk("mid_pulse2_wl", 32'(wl), 32'b010);
    @(negedge clk); reset = 1'b1; s_if.s_valid = 1'b0;
    step();
    @(negedge clk); reset = 1'b0;
    chk("midrst_wl", 32'(wl), 32'd0);
    chk("midrst_bl", 32'(bl), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_row", 32'(cur_row), 32'd0);
    chk("midrst_ready", 32'(s_if.s_ready), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'(IDLE));

    // Clean load after the reset
    pulse_start();
    chk("post_rst_state", 32'(dbg_state), 32'(LOAD));
    nominal_load();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
